// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller takes the master side; the datapath or bench takes slave.
interface multicycle_control_if;
  logic [2:0]  opcode;
  logic        mem_ready;
  logic        pc_write;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        i_or_d;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic [1:0]  alu_op;
  logic        jump;
  logic        branch;
  logic        alu_src;
  logic        reg_write;
  logic        sign_or_zero;
  logic        instr_done;
  logic [15:0] retired;
  logic        halted;
  logic [1:0]  err_code;
  logic [2:0]  state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, i_or_d,
           reg_dst, mem_to_reg, alu_op, jump, branch, alu_src, reg_write,
           sign_or_zero, instr_done, retired, halted, err_code, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, i_or_d,
           reg_dst, mem_to_reg, alu_op, jump, branch, alu_src, reg_write,
           sign_or_zero, instr_done, retired, halted, err_code, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM with memory wait timeout and retire counter.
//   state  | meaning
//   FETCH  | read instruction, wait for mem_ready, write IR and PC+1
//   DECODE | latch opcode; j completes here
//   EXEC   | ALU operation for the latched op
//   MEM    | data access for lw/sw, wait for mem_ready
//   WB     | register write-back, retire
//   ERR    | halted on timeout or illegal opcode until reset
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLI  = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JAL  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_ILL  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  state_t           state_q, state_nxt;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      retired_q;
  logic [1:0]       err_q, err_nxt;
  logic             timeout;
  logic [6:0]       fld;

  logic       pc_write, ir_write, mem_read, mem_write, i_or_d;
  logic [1:0] reg_dst, mem_to_reg, alu_op, err_code;
  logic       jump, alu_src, reg_write, sign_or_zero, instr_done, halted;
  logic [15:0] retired;
  logic [2:0] dbg_state;

  // {reg_dst, mem_to_reg, alu_op, alu_src}
  function automatic logic [6:0] op_fields(input logic [2:0] op);
    case (op)
      OP_ADD:  op_fields = 7'b01_00_00_0;
      OP_SLI:  op_fields = 7'b00_00_10_1;
      OP_ADDI: op_fields = 7'b00_00_00_1;
      OP_LW:   op_fields = 7'b00_01_11_1;
      OP_SW:   op_fields = 7'b00_00_11_1;
      OP_JAL:  op_fields = 7'b10_10_00_0;
      default: op_fields = 7'b00_00_00_0;
    endcase
  endfunction

  assign fld     = op_fields(op_q);
  assign timeout = (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) && !bus.mem_ready;

  always_comb begin
    state_nxt = state_q;
    err_nxt   = err_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_nxt = S_DECODE;
        end else if (timeout) begin
          state_nxt = S_ERR;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_J:    state_nxt = S_FETCH;
          OP_JAL:  state_nxt = S_WB;
          OP_ILL: begin
            state_nxt = S_ERR;
            err_nxt   = ERR_ILLEGAL;
          end
          default: state_nxt = S_EXEC;
        endcase
      end
      S_EXEC:  state_nxt = ((op_q == OP_LW) || (op_q == OP_SW)) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.mem_ready) begin
          state_nxt = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else if (timeout) begin
          state_nxt = S_ERR;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      S_WB:    state_nxt = S_FETCH;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= 3'b000;
      cnt_q     <= '0;
      retired_q <= 16'd0;
      err_q     <= 2'b00;
    end else begin
      state_q <= state_nxt;
      err_q   <= err_nxt;
      if (state_q == S_DECODE) op_q <= bus.opcode;
      // any state change clears the counter, so it starts at 0 on FETCH/MEM entry
      if (state_nxt != state_q) begin
        cnt_q <= '0;
      end else if (((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.mem_ready) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (instr_done) retired_q <= retired_q + 16'd1;
    end
  end

  always_comb begin
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    i_or_d       = 1'b0;
    reg_dst      = 2'b00;
    mem_to_reg   = 2'b00;
    alu_op       = 2'b00;
    jump         = 1'b0;
    alu_src      = 1'b0;
    reg_write    = 1'b0;
    sign_or_zero = 1'b1;
    instr_done   = 1'b0;
    halted       = 1'b0;
    err_code     = 2'b00;
    retired      = 16'd0;
    dbg_state    = 3'd0;
    if (!reset) begin
      dbg_state = state_q;
      retired   = retired_q;
      err_code  = err_q;
      halted    = (state_q == S_ERR);
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = bus.mem_ready;
          pc_write = bus.mem_ready;
        end
        S_DECODE: begin
          if (bus.opcode == OP_J) begin
            jump       = 1'b1;
            pc_write   = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_EXEC: begin
          alu_op  = fld[2:1];
          alu_src = fld[0];
        end
        S_MEM: begin
          i_or_d     = 1'b1;
          alu_op     = 2'b11;
          mem_read   = (op_q == OP_LW);
          mem_write  = (op_q == OP_SW);
          instr_done = (op_q == OP_SW) && bus.mem_ready;
        end
        S_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          reg_dst    = fld[6:5];
          mem_to_reg = fld[4:3];
          jump       = (op_q == OP_JAL);
          pc_write   = (op_q == OP_JAL);
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.ir_write     = ir_write;
  assign bus.mem_read     = mem_read;
  assign bus.mem_write    = mem_write;
  assign bus.i_or_d       = i_or_d;
  assign bus.reg_dst      = reg_dst;
  assign bus.mem_to_reg   = mem_to_reg;
  assign bus.alu_op       = alu_op;
  assign bus.jump         = jump;
  assign bus.branch       = 1'b0;
  assign bus.alu_src      = alu_src;
  assign bus.reg_write    = reg_write;
  assign bus.sign_or_zero = sign_or_zero;
  assign bus.instr_done   = instr_done;
  assign bus.retired      = retired;
  assign bus.halted       = halted;
  assign bus.err_code     = err_code;
  assign bus.state        = dbg_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: an instruction-level model pushes per-cycle expectations,
// a negedge monitor pops and compares them against the controller outputs.
module tb_multicycle_control;
  localparam int TMO = 15;

  localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2;
  localparam logic [2:0] ST_MEM = 3'd3, ST_WB = 3'd4, ST_ERR = 3'd7;
  localparam logic [2:0] ADD = 3'b000, SLI = 3'b001, J = 3'b010, JAL = 3'b011;
  localparam logic [2:0] LW = 3'b100, SW = 3'b101, ILL = 3'b110, ADDI = 3'b111;

  typedef struct packed {
    logic pc_write, ir_write, mem_read, mem_write, i_or_d, jump, branch;
    logic alu_src, reg_write, sign_or_zero, instr_done, halted;
    logic [1:0] reg_dst, mem_to_reg, alu_op, err_code;
  } ctl_t;

  typedef struct packed {
    logic [2:0]  st;
    ctl_t        c;
    logic [15:0] ret;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  multicycle_control_if bus();

  multicycle_control #(.MEM_TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  logic [15:0] m_retired = 16'd0;
  bit          pending_force = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_cyc = 0;
  logic [2:0]  ops [7] = '{ADD, SLI, J, JAL, LW, SW, ADDI};

  function automatic ctl_t base();
    ctl_t c = '0;
    c.sign_or_zero = 1'b1;
    return c;
  endfunction

  // {reg_dst, mem_to_reg, alu_op, alu_src} straight from the op table
  function automatic logic [6:0] fields(input logic [2:0] op);
    case (op)
      ADD:     return {2'b01, 2'b00, 2'b00, 1'b0};
      SLI:     return {2'b00, 2'b00, 2'b10, 1'b1};
      ADDI:    return {2'b00, 2'b00, 2'b00, 1'b1};
      LW:      return {2'b00, 2'b01, 2'b11, 1'b1};
      SW:      return {2'b00, 2'b00, 2'b11, 1'b1};
      JAL:     return {2'b10, 2'b10, 2'b00, 1'b0};
      default: return 7'd0;
    endcase
  endfunction

  function automatic logic [2:0] rnd3();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock of stimulus plus the expectation for that same cycle.
  task automatic cycle(input logic [2:0] st, input ctl_t c, input logic mr,
                       input logic [2:0] opc, input bit rst);
    @(posedge clk);
    #1;
    reset = rst;
    bus.mem_ready = mr;
    bus.opcode = opc;
    if (pending_force) begin
      pending_force = 1'b0;
      force dut.retired_q = 16'hffff;
      #1;
      release dut.retired_q;
      m_retired = 16'hffff;
    end
    if (rst) m_retired = 16'd0;
    exp_q.push_back('{st, c, m_retired});
    if (c.instr_done) m_retired = m_retired + 16'd1;
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(ST_FETCH, base(), rnd1(), rnd3(), 1'b1);
  endtask

  task automatic err_phase(input logic [1:0] code, input int n);
    ctl_t c;
    for (int i = 0; i < n; i++) begin
      c = base();
      c.halted = 1'b1;
      c.err_code = code;
      cycle(ST_ERR, c, rnd1(), rnd3(), 1'b0);
    end
  endtask

  // d idle cycles then mem_ready; status 0 done, 1 timed out, 2 reset-aborted
  task automatic wait_phase(input logic [2:0] st, input logic [2:0] op, input int d,
                            input bit abort, output int status);
    ctl_t c;
    logic mr;
    status = 0;
    for (int i = 0; i <= d; i++) begin
      if (abort && i == d) begin
        reset_cycles(1);
        status = 2;
        return;
      end
      mr = (i == d);
      c = base();
      if (st == ST_FETCH) begin
        c.mem_read = 1'b1;
        c.ir_write = mr;
        c.pc_write = mr;
      end else begin
        c.i_or_d = 1'b1;
        c.alu_op = 2'b11;
        c.mem_read = (op == LW);
        c.mem_write = (op == SW);
        c.instr_done = mr && (op == SW);
      end
      cycle(st, c, mr, rnd3(), 1'b0);
      if (!mr && i == TMO - 1) begin
        status = 1;
        return;
      end
    end
  endtask

  task automatic do_instr(input logic [2:0] op, input int df, input int dm, input bit abort);
    ctl_t c;
    int s;
    logic [6:0] f;
    f = fields(op);
    wait_phase(ST_FETCH, op, df, 1'b0, s);
    if (s == 1) begin
      err_phase(2'b01, 20);
      return;
    end
    c = base();
    if (op == J) begin
      c.jump = 1'b1;
      c.pc_write = 1'b1;
      c.instr_done = 1'b1;
    end
    cycle(ST_DECODE, c, rnd1(), op, 1'b0);
    if (op == J) return;
    if (op == ILL) begin
      err_phase(2'b10, 5);
      return;
    end
    if (op != JAL) begin
      c = base();
      c.alu_op = f[2:1];
      c.alu_src = f[0];
      cycle(ST_EXEC, c, rnd1(), rnd3(), 1'b0);
    end
    if (op == LW || op == SW) begin
      wait_phase(ST_MEM, op, dm, abort, s);
      if (s == 1) err_phase(2'b01, 20);
      if (s != 0 || op == SW) return;
    end
    c = base();
    c.reg_write = 1'b1;
    c.instr_done = 1'b1;
    c.reg_dst = f[6:5];
    c.mem_to_reg = f[4:3];
    c.jump = (op == JAL);
    c.pc_write = (op == JAL);
    cycle(ST_WB, c, rnd1(), rnd3(), 1'b0);
  endtask

  function automatic ctl_t sample();
    ctl_t a;
    a.pc_write = bus.pc_write;
    a.ir_write = bus.ir_write;
    a.mem_read = bus.mem_read;
    a.mem_write = bus.mem_write;
    a.i_or_d = bus.i_or_d;
    a.jump = bus.jump;
    a.branch = bus.branch;
    a.alu_src = bus.alu_src;
    a.reg_write = bus.reg_write;
    a.sign_or_zero = bus.sign_or_zero;
    a.instr_done = bus.instr_done;
    a.halted = bus.halted;
    a.reg_dst = bus.reg_dst;
    a.mem_to_reg = bus.mem_to_reg;
    a.alu_op = bus.alu_op;
    a.err_code = bus.err_code;
    return a;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    ctl_t a;
    n_cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = sample();
      n_cmp++;
      if (bus.state !== e.st) begin
        n_bad++;
        $display("FAIL state cyc=%0d got %0d want %0d", n_cyc, bus.state, e.st);
      end
      n_cmp++;
      if (a !== e.c) begin
        n_bad++;
        $display("FAIL controls cyc=%0d st=%0d got %h want %h", n_cyc, e.st, a, e.c);
      end
      n_cmp++;
      if (bus.retired !== e.ret) begin
        n_bad++;
        $display("FAIL retired cyc=%0d got %h want %h", n_cyc, bus.retired, e.ret);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.mem_ready = 1'b0;
    bus.opcode = 3'b000;
    reset_cycles(2);
    do_instr(ADD, 0, 0, 1'b0);
    do_instr(LW, 0, 3, 1'b0);
    do_instr(J, 0, 0, 1'b0);
    do_instr(JAL, 0, 0, 1'b0);
    do_instr(SLI, TMO - 1, 0, 1'b0);   // ready on the last allowed wait cycle
    do_instr(SW, 0, TMO - 1, 1'b0);
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 6);
      do_instr(ops[k],
               ($urandom_range(0, 9) == 0) ? TMO - 1 : $urandom_range(0, 3),
               ($urandom_range(0, 9) == 0) ? TMO - 1 : $urandom_range(0, 3), 1'b0);
    end
    do_instr(ADD, TMO, 0, 1'b0);
    reset_cycles(2);
    do_instr(LW, 1, TMO, 1'b0);
    reset_cycles(1);
    do_instr(ILL, 0, 0, 1'b0);
    reset_cycles(1);
    do_instr(ADD, 0, 0, 1'b0);
    do_instr(SW, 0, 3, 1'b1);
    do_instr(ADDI, 0, 0, 1'b0);
    pending_force = 1'b1;
    do_instr(J, 0, 0, 1'b0);
    do_instr(ADD, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum consecutive wait cycles for mem_ready in FETCH or MEM.
REQ-002 SHALL have parameter CNT_W, default 4: width of the wait counter, which holds values up to MEM_TIMEOUT.
REQ-003 SHALL have port clk  in  1  rising-edge clock, the only clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port opcode  in  3  instruction opcode from the IR, valid in DECODE.
REQ-006 SHALL have port mem_ready  in  1  memory access complete this cycle.
REQ-007 SHALL have ports pc_write, ir_write, mem_read, mem_write, i_or_d  out  1 each  datapath strobes.
REQ-008 SHALL have ports reg_dst, mem_to_reg, alu_op  out  2 each, and jump, branch, alu_src, reg_write, sign_or_zero  out  1 each.
REQ-009 SHALL have port instr_done  out  1  single-cycle pulse, one instruction retired.
REQ-010 SHALL have port retired  out  16  count of retired instructions.
REQ-011 SHALL have ports halted  out  1 and err_code  out  2: 01 = memory timeout, 10 = illegal opcode.
REQ-012 SHALL have port state  out  3  current state, for debug.

Function
REQ-013 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and ERR=7.
REQ-014 SHALL derive all outputs combinationally from state and the latched op (Moore); no output depends on mem_ready except the FETCH/MEM exit strobes.
REQ-015 FETCH: mem_read=1, i_or_d=0.
  - When mem_ready=1: ir_write=1, pc_write=1 (PC+1) in that cycle, and the next state is DECODE.
  - Otherwise the block stays in FETCH.
REQ-016 DECODE: the block SHALL latch opcode into op.
  - 010 (j): jump=1, pc_write=1, instr_done=1, next state FETCH.
  - 011 (jal): next state WB.
  - 000, 001, 100, 101, 111: next state EXEC.
  - 110: next state ERR with err_code=10.
REQ-017 EXEC: alu_op and alu_src per the op table.
  - 100 or 101: next state MEM.
  - Otherwise: next state WB.
REQ-018 MEM: i_or_d=1 and alu_op=11; mem_read=1 for lw, mem_write=1 for sw.
  - On mem_ready, lw goes to WB.
  - On mem_ready, sw goes to FETCH with instr_done=1.
  - Otherwise the block holds in MEM.
REQ-019 WB: reg_write=1 with reg_dst and mem_to_reg per the op table, instr_done=1, next state FETCH.
  - For jal, jump=1 and pc_write=1 in the same cycle.
REQ-020 Op table (reg_dst, mem_to_reg, alu_op, alu_src):
  - add 01,00,00,0
  - sli 00,00,10,1
  - addi 00,00,00,1
  - lw 00,01,11,1
  - sw 00,00,11,1
  - jal 10,10,00,0
REQ-021 Outside the states named above, every strobe SHALL be 0 and the 2-bit fields SHALL be 00; branch SHALL be 0 always and sign_or_zero SHALL be 1 always.
REQ-022 The wait counter SHALL clear on entry to FETCH or MEM and increment on each cycle spent there with mem_ready=0.
REQ-023 If the counter equals MEM_TIMEOUT-1 and mem_ready=0, the next state SHALL be ERR with err_code=01.
  - mem_ready=1 in that same cycle wins and the normal transition is taken.
REQ-024 ERR: all strobes SHALL be 0 and halted=1; ERR and err_code SHALL hold until reset.
REQ-025 retired SHALL increment on every instr_done cycle and wrap from FFFF to 0000.
REQ-026 Each instruction takes the following fixed cycle count, counting FETCH and MEM as one cycle each when mem_ready arrives immediately:
  - j: 2 cycles.
  - jal: 3 cycles.
  - add, sli, addi: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.

Reset
REQ-027 With reset=1 at a rising edge, the next state SHALL be FETCH, and the following SHALL clear: op=000, the wait counter, retired, err_code and halted.
REQ-028 While reset=1, every output SHALL be forced combinationally to its reset value: all strobes 0, 2-bit fields 00, sign_or_zero=1 and instr_done=0.
REQ-029 Reset SHALL take effect from any state, including mid-MEM and ERR, and SHALL abandon any access in progress without a retire.

Verification
REQ-030 After reset, add (000) with mem_ready=1 -> states 0,1,2,4; reg_dst=01 and reg_write=1 in WB; retired=1.
REQ-031 lw (100) with mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles with mem_read=1 and i_or_d=1; then WB with mem_to_reg=01; 8 cycles total.
REQ-032 j then jal back-to-back -> j: pc_write=1 and jump=1 in DECODE; jal: WB with reg_dst=10, mem_to_reg=10, jump=1; retired=2.
REQ-033 mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> ERR entered after 15 wait cycles; halted=1, err_code=01, held for 20 more cycles; on the 15th wait cycle, mem_ready=1 instead -> normal entry to DECODE.
REQ-034 Opcode 110 -> ERR with err_code=10; reset asserted during a sw MEM wait -> mem_write drops to 0 that cycle, state=FETCH next, retired=0.
REQ-035 Preset 65535 retirements (force or long run), then one more -> retired wraps to 0.
